// File: rtl/frame_writer_pkg.sv
// frame_writer_pkg: shared widths, FSM states and pixel/address types for the frame writer (FRAME_WRITER_CLAMP_EN selects saturation in pixel_clamp)
package frame_writer_pkg;

   localparam int ADDR_W     = 19;
   localparam int BANK_W     = 3;
   localparam int OFFSET_W   = 16;
   localparam int DATA_W     = 18;
   localparam int PIX_W      = 8;
   localparam int BANK_WORDS = 1 << OFFSET_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE
   } fw_state_e;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic [PIX_W-1:0]         pixel_t;
   typedef logic [DATA_W-1:0]        word_t;
   typedef logic [ADDR_W-1:0]        addr_t;

   // The drawer side decodes the same linear address into bank and offset
   typedef struct packed {
      logic [BANK_W-1:0]   bank;
      logic [OFFSET_W-1:0] offset;
   } bank_addr_t;

   function automatic word_t pixel_word(input pixel_t p);
      return {{(DATA_W-PIX_W){1'b0}}, p};
   endfunction

   function automatic bank_addr_t split_addr(input addr_t a);
      return bank_addr_t'(a);
   endfunction

endpackage

// File: rtl/frame_writer_pixel_clamp.sv
// pixel_clamp: 18-bit signed kernel result to 8-bit pixel, saturating when FRAME_WRITER_CLAMP_EN is defined, truncating otherwise
module pixel_clamp
   import frame_writer_pkg::*;
(
   input  logic signed [DATA_W-1:0] in_data_i,
   output logic [PIX_W-1:0]         pix_o
);

`ifdef FRAME_WRITER_CLAMP_EN
   // Negative results become black, anything above full scale becomes white
   assign pix_o = (in_data_i < 18'sd0)   ? '0 :
                  (in_data_i > 18'sd255) ? '1 :
                  in_data_i[PIX_W-1:0];
`else
   // Upper bits are intentionally dropped by plain truncation
   logic unused_hi;
   assign unused_hi = ^in_data_i[DATA_W-1:PIX_W];
   assign pix_o     = in_data_i[PIX_W-1:0];
`endif

endmodule

// File: rtl/frame_writer.sv
// frame_writer: streams kernel samples into the banked image memory as raster-ordered pixel writes; optional saturation via FRAME_WRITER_CLAMP_EN
module frame_writer
   import frame_writer_pkg::*;
#(
   parameter int Width     = 640,
   parameter int Height    = 480,
   parameter int NUM_BANKS = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   input  logic                     mem_grant,
   output logic                     WriteEnable,
   output logic [DATA_W-1:0]        writeData,
   output logic [ADDR_W-1:0]        adreesMem,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int    PIXELS   = Width * Height;
   localparam addr_t LAST_IDX = addr_t'(PIXELS - 1);

   // A frame must fit in the available banks and the 3-bit bank field
   if (PIXELS < 1 || PIXELS > NUM_BANKS * BANK_WORDS || NUM_BANKS > (1 << BANK_W)) begin : g_bad_geometry
      $error("frame_writer: frame geometry does not fit the image memory banks");
   end

   fw_state_e state_q, state_d;
   addr_t     idx_q, idx_d;
   addr_t     addr_q, addr_d;
   pixel_t    pix_q, pix_d;
   logic      pend_q, pend_d;
   pixel_t    pix;
   logic      accept;
   logic      retire;
   logic      last_accept;

   pixel_clamp u_clamp (
      .in_data_i (in_data),
      .pix_o     (pix)
   );

   assign accept      = in_valid & in_ready;
   assign retire      = pend_q & mem_grant;
   assign last_accept = accept && (idx_q == LAST_IDX);

   // Write strobe is a gate on the registered pending flag so a stall drops it in the same cycle
   assign WriteEnable = retire;
   assign writeData   = pixel_word(pix_q);
   assign adreesMem   = addr_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: run until the last pixel is accepted, then drain the final write
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  state_d = start ? S_RUN : S_IDLE;
         S_RUN:   state_d = last_accept ? S_FLUSH : S_RUN;
         S_FLUSH: state_d = retire ? S_DONE : S_FLUSH;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: accept only while running and the output register is free or draining now
   always_comb begin
      in_ready   = (state_q == S_RUN) && (!pend_q || mem_grant);
      busy       = state_q != S_IDLE;
      frame_done = state_q == S_DONE;
   end

   // Datapath next-state: index counter, output register and pending flag
   always_comb begin
      idx_d  = (state_q == S_IDLE && start) ? '0 :
               last_accept ? '0 :
               accept ? idx_q + 1'b1 : idx_q;
      addr_d = accept ? idx_q : addr_q;
      pix_d  = accept ? pix : pix_q;
      pend_d = accept | (pend_q & ~mem_grant);
   end

   // Datapath registers; reset abandons any pending write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         addr_q <= '0;
         pix_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         addr_q <= addr_d;
         pix_q  <= pix_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: randomized self-checking bench for frame_writer against a queue-based write model
module tb_frame_writer;
   import frame_writer_pkg::*;

   localparam int SW = 4, SH = 2;
   localparam int BW = 128, BH = 513;

   typedef struct {
      int a;
      int d;
   } wr_t;

   logic clk = 1'b0, rst_n = 1'b0, start_s = 1'b0, start_b = 1'b0;
   logic in_valid = 1'b0, mem_grant = 1'b0, sel_big = 1'b0;
   logic signed [17:0] in_data = '0;
   logic rdy_s, we_s, busy_s, fd_s, rdy_b, we_b, busy_b, fd_b;
   logic [17:0] wd_s, wd_b;
   logic [18:0] ad_s, ad_b;
   logic rdy, we, bsy, fd;
   logic [17:0] wd;
   logic [18:0] ad;
   int checks = 0, errors = 0;
   int clamp_tab[8] = '{-5, 300, 128, -131072, 131071, 255, 0, 256};

   always #5 clk = ~clk;

   frame_writer #(.Width(SW), .Height(SH), .NUM_BANKS(5)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_s), .mem_grant(mem_grant), .WriteEnable(we_s), .writeData(wd_s),
      .adreesMem(ad_s), .busy(busy_s), .frame_done(fd_s));

   frame_writer #(.Width(BW), .Height(BH), .NUM_BANKS(5)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_b), .mem_grant(mem_grant), .WriteEnable(we_b), .writeData(wd_b),
      .adreesMem(ad_b), .busy(busy_b), .frame_done(fd_b));

   assign rdy = sel_big ? rdy_b : rdy_s;
   assign we  = sel_big ? we_b : we_s;
   assign bsy = sel_big ? busy_b : busy_s;
   assign fd  = sel_big ? fd_b : fd_s;
   assign wd  = sel_big ? wd_b : wd_s;
   assign ad  = sel_big ? ad_b : ad_s;

   function automatic int ref_pix(input int d);
`ifdef FRAME_WRITER_CLAMP_EN
      return d < 0 ? 0 : d > 255 ? 255 : d;
`else
      return ((d % 256) + 256) % 256;
`endif
   endfunction

   // One frame: pixel k must be written to address k with the converted sample, in order
   task automatic run_frame(input bit big, input int n, input int gmode, input int dmode, input bit rvalid,
                            output int done_cyc, output int last_a, output bit crossed);
      wr_t q[$];
      wr_t e;
      int acc = 0, wr = 0, cyc = 0, prev_a = -1, obs_a = 0;
      bit done_seen = 0, done_due = 0, exp_rdy, exp_we, do_acc, do_ret;
      sel_big = big;
      done_cyc = -1;
      last_a = -1;
      crossed = 0;
      if (big) start_b = 1'b1; else start_s = 1'b1;
      @(posedge clk); #1;
      while (!done_seen && cyc < 4 * n + 100) begin
         start_s = !big && cyc == 2;
         start_b = big && cyc == 2;
         mem_grant = gmode == 0 ? 1'b1 : gmode == 1 ? !(cyc >= 3 && cyc < 6) : ($urandom_range(3) != 0);
         in_valid = rvalid ? ($urandom_range(3) != 0) : 1'b1;
         in_data = dmode == 0 ? 18'(acc) : dmode == 1 ? 18'(clamp_tab[acc % 8]) : 18'($urandom_range(262143));
         #1;
         exp_rdy = (acc < n) && (q.size() == 0 || mem_grant);
         exp_we = (q.size() != 0) && mem_grant;
         checks++;
         if (rdy !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready cyc %0d got %b exp %b", cyc, rdy, exp_rdy);
         end
         checks++;
         if (we !== exp_we) begin
            errors++;
            $display("FAIL WriteEnable cyc %0d got %b exp %b", cyc, we, exp_we);
         end
         if (q.size() != 0) begin
            checks++;
            if (ad !== 19'(q[0].a) || wd !== 18'(q[0].d)) begin
               errors++;
               $display("FAIL write_port cyc %0d got addr %h data %h exp addr %h data %h", cyc, ad, wd, 19'(q[0].a), 18'(q[0].d));
            end
         end
         checks++;
         if (fd !== done_due || bsy !== 1'b1) begin
            errors++;
            $display("FAIL done_busy cyc %0d got done %b busy %b exp done %b busy 1", cyc, fd, bsy, done_due);
         end
         if (done_due) begin
            done_seen = 1;
            done_cyc = cyc;
         end
         if (exp_we) obs_a = int'(ad);
         do_acc = in_valid && exp_rdy;
         do_ret = exp_we;
         e.a = acc;
         e.d = ref_pix(int'(in_data));
         @(posedge clk); #1;
         if (do_ret) begin
            if (prev_a == 32'h0FFFF && obs_a == 32'h10000) crossed = 1;
            prev_a = obs_a;
            last_a = obs_a;
            void'(q.pop_front());
            wr++;
         end
         done_due = do_ret && wr == n;
         if (do_acc) begin
            q.push_back(e);
            acc++;
         end
         cyc++;
      end
      start_s = 1'b0;
      start_b = 1'b0;
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL frame_timeout got %0d writes exp %0d", wr, n);
      end
      checks++;
      if (bsy !== 1'b0 || fd !== 1'b0 || we !== 1'b0 || rdy !== 1'b0) begin
         errors++;
         $display("FAIL after_frame got busy %b done %b we %b rdy %b exp all 0", bsy, fd, we, rdy);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_s = 1'b1;
      start_b = 1'b1;
      in_valid = 1'b1;
      mem_grant = 1'b1;
      in_data = 18'd77;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if ({rdy_s, we_s, busy_s, fd_s, wd_s, ad_s, rdy_b, we_b, busy_b, fd_b, wd_b, ad_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got s:%b%b%b%b %h %h b:%b%b%b%b %h %h exp all 0",
                     rdy_s, we_s, busy_s, fd_s, wd_s, ad_s, rdy_b, we_b, busy_b, fd_b, wd_b, ad_b);
         end
      end
      start_s = 1'b0;
      start_b = 1'b0;
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         in_valid = $urandom_range(1) != 0;
         #1;
         checks++;
         if ({rdy_s, we_s, busy_s, fd_s, rdy_b, we_b, busy_b, fd_b} !== '0) begin
            errors++;
            $display("FAIL idle_outputs got s:%b%b%b%b b:%b%b%b%b exp all 0",
                     rdy_s, we_s, busy_s, fd_s, rdy_b, we_b, busy_b, fd_b);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_full_frame();
      int dc, la;
      bit cr;
      run_frame(1'b0, SW * SH, 0, 0, 1'b0, dc, la, cr);
      checks++;
      if (dc != SW * SH + 1 || la != SW * SH - 1) begin
         errors++;
         $display("FAIL full_frame got done_cyc %0d last %0d exp %0d %0d", dc, la, SW * SH + 1, SW * SH - 1);
      end
   endtask

   task automatic test_clamp();
      int dc, la;
      bit cr;
      run_frame(1'b0, SW * SH, 0, 1, 1'b0, dc, la, cr);
      checks++;
      if (la != SW * SH - 1) begin
         errors++;
         $display("FAIL clamp_frame got last %0d exp %0d", la, SW * SH - 1);
      end
   endtask

   task automatic test_stall();
      int dc, la;
      bit cr;
      run_frame(1'b0, SW * SH, 1, 0, 1'b0, dc, la, cr);
      checks++;
      if (dc != SW * SH + 4 || la != SW * SH - 1) begin
         errors++;
         $display("FAIL stall_frame got done_cyc %0d last %0d exp %0d %0d", dc, la, SW * SH + 4, SW * SH - 1);
      end
   endtask

   task automatic test_random();
      int dc, la;
      bit cr;
      repeat (6) begin
         run_frame(1'b0, SW * SH, 2, 2, 1'b1, dc, la, cr);
         checks++;
         if (la != SW * SH - 1) begin
            errors++;
            $display("FAIL random_frame got last %0d exp %0d", la, SW * SH - 1);
         end
      end
   endtask

   task automatic test_abort();
      int dc, la;
      bit cr;
      sel_big = 1'b0;
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      in_valid = 1'b1;
      mem_grant = 1'b1;
      in_data = 18'd9;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({we_s, busy_s, fd_s, rdy_s, ad_s, wd_s} !== '0) begin
         errors++;
         $display("FAIL abort_reset got we %b busy %b done %b rdy %b addr %h data %h exp all 0",
                  we_s, busy_s, fd_s, rdy_s, ad_s, wd_s);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (fd_s !== 1'b0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got done %b busy %b exp 0 0", fd_s, busy_s);
         end
      end
      run_frame(1'b0, SW * SH, 0, 0, 1'b0, dc, la, cr);
      checks++;
      if (dc != SW * SH + 1 || la != SW * SH - 1) begin
         errors++;
         $display("FAIL abort_next_frame got done_cyc %0d last %0d exp %0d %0d", dc, la, SW * SH + 1, SW * SH - 1);
      end
   endtask

   task automatic test_bank_crossing();
      int dc, la;
      bit cr;
      run_frame(1'b1, BW * BH, 0, 0, 1'b0, dc, la, cr);
      checks++;
      if (!cr || la != BW * BH - 1 || dc != BW * BH + 1) begin
         errors++;
         $display("FAIL bank_crossing got crossed %b last %h done_cyc %0d exp 1 %h %0d", cr, la, dc, BW * BH - 1, BW * BH + 1);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_clamp();
      test_stall();
      test_random();
      test_abort();
      test_bank_crossing();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
